// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: TX word buffer. With UART_TX_FIFO_EN defined it is a DEPTH-entry
// synchronous FIFO; otherwise a single holding register (full = ~empty).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    level   = wp - rp;
    empty   = (wp == rp);
    full    = (level == (AW+1)'(DEPTH));
    dout    = mem[rp[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end
`else
  logic         vld;
  logic [W-1:0] hold;

  always_comb begin
    full  = vld;
    empty = !vld;
    level = ($clog2(DEPTH)+1)'(vld);
    dout  = hold;
  end

  // Push is refused while occupied, so a same-cycle pop simply empties the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= 1'b0;
      hold <= '0;
    end else if (push && !vld) begin
      vld  <= 1'b1;
      hold <= din;
    end else if (pop && vld) begin
      vld  <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: buffered UART transmitter, LSB-first, optional parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BAUD_W     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sel,
  input  logic                          set,
  input  logic [DATA_W-1:0]             din,
  input  logic [BAUD_W-1:0]             baud,
  input  logic [1:0]                    parity,
  input  logic                          stop2,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          tx_en,
  output logic                          tx_out
);

  localparam int BIW = $clog2(DATA_W);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
    $error("uart_tx_fifo_param: DATA_W out of range");
  end

  state_t            state;
  logic [DATA_W-1:0] head, shreg;
  logic [BAUD_W-1:0] cnt, reload, reload_q;
  logic [1:0]        par_q;
  logic [BIW-1:0]    bit_idx;
  logic              par_bit, stop2_q, stop_idx, bit_done, pop;

  uart_tx_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (set),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Launch from IDLE, or from the final stop-bit clock so frames run back-to-back.
  always_comb begin
    reload   = (baud == '0) ? '0 : baud - BAUD_W'(1);
    bit_done = (cnt == '0);
    pop      = sel && !empty &&
               (state == IDLE || (state == STOP && bit_done && stop_idx == stop2_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      tx_en    <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      reload_q <= '0;
      par_q    <= PAR_NONE;
      par_bit  <= 1'b0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
      bit_idx  <= '0;
    end else if (pop) begin
      state    <= START;
      tx_out   <= 1'b0;
      tx_en    <= 1'b1;
      shreg    <= head;
      par_bit  <= ^head;
      cnt      <= reload;
      reload_q <= reload;
      par_q    <= (parity == PAR_EVEN || parity == PAR_ODD) ? parity : PAR_NONE;
      stop2_q  <= stop2;
      stop_idx <= 1'b0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          tx_en  <= 1'b0;
        end
        START: begin
          if (bit_done) begin
            state  <= DATA;
            tx_out <= shreg[0];
            cnt    <= reload_q;
          end else cnt <= cnt - BAUD_W'(1);
        end
        DATA: begin
          if (bit_done) begin
            cnt <= reload_q;
            if (bit_idx == BIW'(DATA_W-1)) begin
              if (par_q != PAR_NONE) begin
                state  <= PAR;
                tx_out <= (par_q == PAR_ODD) ? ~par_bit : par_bit;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + BIW'(1);
              shreg   <= shreg >> 1;
              tx_out  <= shreg[1];
            end
          end else cnt <= cnt - BAUD_W'(1);
        end
        PAR: begin
          if (bit_done) begin
            state  <= STOP;
            tx_out <= 1'b1;
            cnt    <= reload_q;
          end else cnt <= cnt - BAUD_W'(1);
        end
        STOP: begin
          if (bit_done) begin
            if (stop_idx == stop2_q) begin
              state  <= IDLE;
              tx_en  <= 1'b0;
              tx_out <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
              cnt      <= reload_q;
            end
          end else cnt <= cnt - BAUD_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench for uart_tx_fifo_param: per-clock comparison against a frame-level line model.
module tb_uart_tx_fifo_param;
  localparam int DW = 8;
  localparam int BW = 20;
  localparam int FD = 8;
`ifdef UART_TX_FIFO_EN
  localparam int EFF_DEPTH = FD;
`else
  localparam int EFF_DEPTH = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, sel, set, stop2;
  logic [DW-1:0]     din;
  logic [BW-1:0]     baud;
  logic [1:0]        parity;
  logic              full, empty, tx_en, tx_out;
  logic [$clog2(FD):0] level;

  int    total = 0;
  int    bad = 0;
  int    en_clocks = 0;
  string phase = "init";

  logic [DW-1:0] mq[$];  // words accepted but not yet launched
  bit            lq[$];  // expected line level for each upcoming clock of the current frame

  uart_tx_fifo_param #(
    .DATA_W     (DW),
    .BAUD_W     (BW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .set    (set),
    .din    (din),
    .baud   (baud),
    .parity (parity),
    .stop2  (stop2),
    .full   (full),
    .empty  (empty),
    .level  (level),
    .tx_en  (tx_en),
    .tx_out (tx_out)
  );

  always #5 clk = ~clk;

  function automatic void add_frame(logic [DW-1:0] d, logic [BW-1:0] b, logic [1:0] p, logic s2);
    int n;
    bit bits[$];
    n = (b == 0) ? 1 : int'(b);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (p == 2'b01) bits.push_back(^d);
    else if (p == 2'b10) bits.push_back(~^d);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < n; k++) lq.push_back(bits[i]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // One clock: decide launches/pushes from the pre-edge state, then compare all outputs.
  task automatic step();
    bit pop_now, push_now, eo, ee;
    pop_now  = sel && (mq.size() > 0) && (lq.size() == 0);
    push_now = set && (mq.size() < EFF_DEPTH);
    if (pop_now) add_frame(mq.pop_front(), baud, parity, stop2);
    if (push_now) mq.push_back(din);
    @(posedge clk);
    @(negedge clk);
    if (lq.size() > 0) begin
      eo = lq.pop_front();
      ee = 1'b1;
    end else begin
      eo = 1'b1;
      ee = 1'b0;
    end
    if (tx_en === 1'b1) en_clocks++;
    chk("tx_out", tx_out, eo);
    chk("tx_en", tx_en, ee);
    chk("level", level, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == EFF_DEPTH);
  endtask

  task automatic push(logic [DW-1:0] d);
    set = 1'b1;
    din = d;
    step();
    set = 1'b0;
  endtask

  task automatic run_idle(int limit);
    int n = 0;
    while ((lq.size() != 0 || (sel && mq.size() != 0)) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $error("FAIL %s/timeout observed=%0d expected<%0d", phase, n, limit);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; set = 1'b0; din = '0;
    baud = 20; parity = 2'b00; stop2 = 1'b0;
    #1 rst = 1'b0;
    #1;
    phase = "reset";
    chk("tx_out", tx_out, 1);
    chk("tx_en", tx_en, 0);
    chk("empty", empty, 1);
    chk("full", full, 0);
    chk("level", level, 0);
    @(negedge clk) rst = 1'b1;
    step();

    phase = "8n1";
    sel = 1'b1; en_clocks = 0;
    push(8'h33);
    run_idle(1000);
    step();
    chk("frame_len", en_clocks, 200);

    phase = "8e2";
    parity = 2'b01; stop2 = 1'b1; en_clocks = 0;
    push(8'h07);
    run_idle(1000);
    step();
    chk("frame_len", en_clocks, 240);

    phase = "8o2";
    parity = 2'b10; en_clocks = 0;
    push(8'h07);
    run_idle(1000);
    step();
    chk("frame_len", en_clocks, 240);

    phase = "fifo_full";
    parity = 2'b00; stop2 = 1'b0; baud = 3; sel = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push(DW'(i));
      if (i == 8) begin
        chk("full8", full, 1);
        chk("level8", level, EFF_DEPTH);
      end
    end
    chk("level9", level, EFF_DEPTH);
    en_clocks = 0; sel = 1'b1;
    run_idle(2000);
    step();
    chk("b2b_len", en_clocks, EFF_DEPTH * 30);
    chk("drained_empty", empty, 1);
    chk("drained_en", tx_en, 0);

    phase = "sel_drop";
    baud = 4; sel = 1'b0;
    push(8'hA1);
    push(8'h5E);
    sel = 1'b1;
    repeat (19) step();
    sel = 1'b0;
    run_idle(500);
    repeat (5) step();
    chk("held_level", level, (EFF_DEPTH > 1) ? 1 : 0);
    chk("held_line", tx_out, 1);
    sel = 1'b1;
    run_idle(500);
    step();

    phase = "async_rst";
    baud = 5;
    push(8'hC3);
    push(8'h3C);
    repeat (15) step();
    #2 rst = 1'b0;
    #1;
    chk("tx_out", tx_out, 1);
    chk("tx_en", tx_en, 0);
    chk("level", level, 0);
    chk("empty", empty, 1);
    mq.delete();
    lq.delete();
    @(negedge clk) rst = 1'b1;
    repeat (3) step();

    phase = "baud0";
    baud = 0; en_clocks = 0;
    push(8'hA5);
    run_idle(200);
    step();
    chk("frame_len", en_clocks, 10);

    phase = "baud1";
    baud = 1; en_clocks = 0;
    push(8'h5A);
    run_idle(200);
    step();
    chk("frame_len", en_clocks, 10);

    phase = "baud_change";
    baud = 2; en_clocks = 0;
    push(8'h3C);
    repeat (3) step();
    push(8'hC3);
    baud = 5;
    run_idle(500);
    step();
    chk("two_frame_len", en_clocks, 70);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      set = ($urandom_range(0, 2) == 0);
      din = DW'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        baud   = BW'($urandom_range(0, 3));
        parity = 2'($urandom_range(0, 3));
        stop2  = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 24) == 0) sel = ~sel;
      step();
    end
    set = 1'b0; sel = 1'b1;
    run_idle(5000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
- Parametrised next-generation UART transmitter.
- Accepts data words into a small FIFO and serialises them LSB-first.
- Data width, parity mode, stop-bit count and baud divisor are all configurable.
- Sits between the CPU/bus register interface and the TX pin; drives line-idle-high framing with back-to-back frames and no idle gap.

Parameters:
- DATA_W, 8, data bits per frame (legal 5..9).
- BAUD_W, 20, width of baud divisor input.
- FIFO_DEPTH, 8, TX FIFO entries (power of two, 2..64).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- sel  in  1  transmitter enable; 0 = stop launching new frames.
- set  in  1  write strobe; pushes din into FIFO when not full.
- din  in  DATA_W  data word to transmit.
- baud  in  BAUD_W  clocks per bit; sampled at each frame start.
- parity  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
- stop2  in  1  1 = two stop bits, 0 = one; sampled at frame start.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- tx_en  out  1  high while a frame is on the line.
- tx_out  out  1  serial line.

Behaviour:
- Reset (rst=0, async): tx_out=1, tx_en=0, empty=1, full=0, level=0; FSM to IDLE; FIFO pointers cleared.
- Push: set=1 and full=0 writes din at the clock edge.
  - Push while full is dropped silently; FIFO contents are unchanged.
  - Push and pop in the same cycle leave level unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - If sel=1 and empty=0: pop the head into the shift register; latch baud, parity and stop2; go to START.
  - tx_out and tx_en change on the next edge, so frame latency from pop is 1 cycle.
- Bit timing: each bit lasts max(baud,1) clocks (baud=0 behaves as 1), counted by a down-counter.
- START: tx_out=0 for one bit, then DATA.
- DATA:
  - DATA_W bits, LSB first.
  - Then PAR if parity is 01 or 10, else STOP.
- PAR:
  - Even parity: tx_out = XOR of data.
  - Odd parity: tx_out = ~XOR of data.
- STOP:
  - tx_out=1 for 1 or 2 bits.
  - On the last stop-bit clock, if sel=1 and empty=0, pop and go straight to START (no idle gap); otherwise go to IDLE and drop tx_en.
- sel deasserted mid-frame: the current frame completes; no new frame is launched.
- Input changes mid-frame: baud, parity and stop2 changes take effect only at the next frame start.
- Frame length in clocks: baud*(1+DATA_W+P+S), where P is 0/1 and S is 1/2.
- Reset mid-frame: line returns high immediately (async); FIFO is flushed.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined: FIFO of FIFO_DEPTH entries as above.
- Undefined:
  - Single holding register (depth 1).
  - full = ~empty; level is 0 or 1.
  - FIFO_DEPTH is ignored; all other behaviour is identical.

Decomposition:
- Package uart_pkg:
  - FSM state encoding.
  - Parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
  - Legal DATA_W bounds.
- Sub-module uart_tx_fifo:
  - Synchronous FIFO parametrised on width and depth.
  - Provides full, empty and level.
  - Replaced by a holding register when UART_TX_FIFO_EN is undefined.

Test Plan:
- Basic 8N1 frame:
  - Stimulus: baud=20, parity=00, stop2=0, sel=1; push 0x33.
  - Required: tx_out low 20 clocks one cycle after pop, then bits 1,1,0,0,1,1,0,0 at 20 clocks each, then high 20 clocks.
  - Required: tx_en high exactly 200 clocks.
- Parity with two stop bits:
  - Stimulus: parity=01, stop2=1, push 0x07.
  - Required: parity bit = 1; two stop bits; frame length 240 clocks at baud=20.
  - Repeat with parity=10: parity bit = 0.
- FIFO full and back-to-back:
  - Stimulus: sel=0; push 9 words 0x01..0x09.
  - Required: full=1 and level=8 after the 8th push; 0x09 dropped.
  - Stimulus: then sel=1.
  - Required: 8 frames back-to-back with no idle clock between stop and start, then empty=1 and tx_en=0.
- sel drop mid-frame:
  - Stimulus: 2 words queued; deassert sel during frame 1 data bit 3.
  - Required: frame 1 completes; line stays high; level=1.
- Async reset mid-frame:
  - Stimulus: assert rst during DATA.
  - Required: tx_out=1, tx_en=0, level=0 without waiting for a clock edge.
- Baud edge cases:
  - baud=0 and baud=1 both give 1 clock per bit.
  - A baud change mid-frame takes effect only on the next frame.
